ddr3_dq_burst_sequencer: RTL and testbench

- Data-path stage directly upstream of the memory I/O pad block.
- On a WRITE it latches one BL8 burst and serializes it onto the pad-side DQ/DM/DQS outputs after CAS write latency, driving the direction select low only for the burst window.
- On a READ it captures eight beats returned through the pad after CAS latency and presents them as one wide word.
- Single-data-rate beat model: one beat per clk.

---
 rtl/ddr3_dq_burst_sequencer_pkg.sv | 23 ++
 rtl/ddr3_dq_burst_sequencer_if.sv | 38 +++
 rtl/ddr3_dq_burst_sequencer_lat_counter.sv | 27 ++
 rtl/ddr3_dq_burst_sequencer.sv | 153 +++++++++++++++
 tb/tb_ddr3_dq_burst_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr3_dq_burst_sequencer_pkg.sv
// Shared types and sizing for the DDR3 DQ burst sequencer.
// The sequencer always moves one BL8 burst, one beat per clk.
package ddr3_seq_pkg;

    localparam int BL_LEN = 8;
    localparam int BEAT_W = 3;
    localparam int LAT_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_BURST,
        RD_WAIT,
        RD_BURST,
        TURN
    } seq_state_e;

    // The latency counter only handles 2..15 without wrapping.
    function automatic logic lat_legal(input int lat);
        return (lat >= 2) && (lat <= 15);
    endfunction

endpackage

// File: rtl/ddr3_dq_burst_sequencer_if.sv
// Host-side command/data bus and pad-side DQ/DM/DQS bus of the burst sequencer.
// The master modport is the controller/pad side, the slave modport is the sequencer.
interface ddr3_dq_burst_sequencer_if
    import ddr3_seq_pkg::*;
#(
    parameter int DQ_W  = 16,
    parameter int DM_W  = 2,
    parameter int DQS_W = 2
);
    logic                     wr_start;
    logic [DQ_W*BL_LEN-1:0]   wr_data;
    logic [DM_W*BL_LEN-1:0]   wr_mask;
    logic                     rd_start;
    logic [DQ_W*BL_LEN-1:0]   rd_data;
    logic                     rd_valid;
    logic                     busy;
    logic                     cmd_err;
    logic                     ddr3_rw;
    logic [DQ_W-1:0]          ddr3_data_out;
    logic [DQ_W*BL_LEN-1:0]   ddr3_data_all_out;
    logic [DM_W-1:0]          ddr3_dm_tdqs_out;
    logic [DQS_W-1:0]         ddr3_dqs_out;
    logic [DQS_W-1:0]         ddr3_dqs_n_out;
    logic [DQ_W-1:0]          ddr3_data_in;

    modport master (
        output wr_start, wr_data, wr_mask, rd_start, ddr3_data_in,
        input  rd_data, rd_valid, busy, cmd_err, ddr3_rw, ddr3_data_out,
               ddr3_data_all_out, ddr3_dm_tdqs_out, ddr3_dqs_out, ddr3_dqs_n_out
    );

    modport slave (
        input  wr_start, wr_data, wr_mask, rd_start, ddr3_data_in,
        output rd_data, rd_valid, busy, cmd_err, ddr3_rw, ddr3_data_out,
               ddr3_data_all_out, ddr3_dm_tdqs_out, ddr3_dqs_out, ddr3_dqs_n_out
    );

endinterface

// File: rtl/ddr3_dq_burst_sequencer_lat_counter.sv
// Loadable 4-bit down-counter used for both CAS write and CAS read latency.
// zero flags the enabled cycle in which the count steps from 1 to 0.
module ddr3_lat_counter
    import ddr3_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             en,
    output logic [LAT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - LAT_W'(1);
        end
    end

    assign zero = en && (count == LAT_W'(1));

endmodule

// File: rtl/ddr3_dq_burst_sequencer.sv
// BL8 DQ burst sequencer: serializes write bursts onto the pad after CWL and
// assembles read bursts returned by the pad after CL.
module ddr3_dq_burst_sequencer
    import ddr3_seq_pkg::*;
#(
    parameter int DQ_W  = 16,
    parameter int DM_W  = 2,
    parameter int DQS_W = 2,
    parameter int BL    = 8,
    parameter int CWL   = 5,
    parameter int CL    = 6
)
(
    input  logic                        clk,
    input  logic                        rst_n,
    ddr3_dq_burst_sequencer_if.slave    bus
);

    if (!lat_legal(CWL)) begin : g_bad_cwl
        $error("ddr3_dq_burst_sequencer: CWL must be in 2..15");
    end
    if (!lat_legal(CL)) begin : g_bad_cl
        $error("ddr3_dq_burst_sequencer: CL must be in 2..15");
    end
    if (BL != BL_LEN) begin : g_bad_bl
        $error("ddr3_dq_burst_sequencer: only BL8 is supported");
    end

    seq_state_e               state;
    logic [BEAT_W-1:0]        beat;
    logic [BEAT_W-1:0]        next_beat;
    logic [DQ_W*BL_LEN-1:0]   wr_buf;
    logic [DM_W*BL_LEN-1:0]   mask_buf;
    logic [DQ_W*BL_LEN-1:0]   rd_buf;
    logic [LAT_W-1:0]         lat_count;
    logic [LAT_W-1:0]         lat_load_val;
    logic                     lat_load;
    logic                     lat_en;
    logic                     lat_zero;
    logic                     any_start;

    assign any_start    = bus.wr_start | bus.rd_start;
    assign lat_load     = (state == IDLE) && any_start;
    assign lat_load_val = bus.wr_start ? LAT_W'(CWL - 1) : LAT_W'(CL - 1);
    assign lat_en       = (state == WR_WAIT) || (state == RD_WAIT);
    assign next_beat    = beat + BEAT_W'(1);

    ddr3_lat_counter u_lat (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lat_load),
        .load_val (lat_load_val),
        .en       (lat_en),
        .count    (lat_count),
        .zero     (lat_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            beat                  <= '0;
            wr_buf                <= '0;
            mask_buf              <= '0;
            rd_buf                <= '0;
            bus.busy              <= 1'b0;
            bus.cmd_err           <= 1'b0;
            bus.rd_valid          <= 1'b0;
            bus.rd_data           <= '0;
            bus.ddr3_rw           <= 1'b1;
            bus.ddr3_data_out     <= '0;
            bus.ddr3_data_all_out <= '0;
            bus.ddr3_dm_tdqs_out  <= '0;
            bus.ddr3_dqs_out      <= '0;
            bus.ddr3_dqs_n_out    <= '1;
        end else begin
            bus.cmd_err  <= (state != IDLE) && any_start;
            bus.rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wr_start) begin
                        wr_buf      <= bus.wr_data;
                        mask_buf    <= bus.wr_mask;
                        bus.busy    <= 1'b1;
                        bus.cmd_err <= bus.rd_start;
                        state       <= WR_WAIT;
                        if (CWL == 2) begin
                            bus.ddr3_rw <= 1'b0;
                        end
                    end else if (bus.rd_start) begin
                        bus.busy <= 1'b1;
                        state    <= RD_WAIT;
                    end
                end
                WR_WAIT: begin
                    // Preamble: pad turns to drive one cycle before beat 0.
                    if (lat_count == LAT_W'(2)) begin
                        bus.ddr3_rw <= 1'b0;
                    end
                    if (lat_zero) begin
                        beat                  <= '0;
                        bus.ddr3_data_out     <= wr_buf[DQ_W-1:0];
                        bus.ddr3_dm_tdqs_out  <= mask_buf[DM_W-1:0];
                        bus.ddr3_dqs_out      <= '1;
                        bus.ddr3_dqs_n_out    <= '0;
                        bus.ddr3_data_all_out <= wr_buf;
                        state                 <= WR_BURST;
                    end
                end
                WR_BURST: begin
                    if (beat == BEAT_W'(BL_LEN - 1)) begin
                        bus.ddr3_rw           <= 1'b1;
                        bus.ddr3_data_out     <= '0;
                        bus.ddr3_dm_tdqs_out  <= '0;
                        bus.ddr3_dqs_out      <= '0;
                        bus.ddr3_dqs_n_out    <= '1;
                        bus.ddr3_data_all_out <= '0;
                        state                 <= TURN;
                    end else begin
                        beat                 <= next_beat;
                        bus.ddr3_data_out    <= wr_buf[next_beat*DQ_W +: DQ_W];
                        bus.ddr3_dm_tdqs_out <= mask_buf[next_beat*DM_W +: DM_W];
                        bus.ddr3_dqs_out     <= {DQS_W{beat[0]}};
                        bus.ddr3_dqs_n_out   <= {DQS_W{~beat[0]}};
                    end
                end
                RD_WAIT: begin
                    if (lat_zero) begin
                        beat  <= '0;
                        state <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    rd_buf[beat*DQ_W +: DQ_W] <= bus.ddr3_data_in;
                    if (beat == BEAT_W'(BL_LEN - 1)) begin
                        bus.rd_data  <= {bus.ddr3_data_in, rd_buf[DQ_W*(BL_LEN-1)-1:0]};
                        bus.rd_valid <= 1'b1;
                        state        <= TURN;
                    end else begin
                        beat <= next_beat;
                    end
                end
                TURN: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_dq_burst_sequencer.sv
// Randomized self-checking bench for ddr3_dq_burst_sequencer (CWL=5, CL=6).
// Expected pad and host activity is derived per cycle from burst timing rules.
module tb_ddr3_dq_burst_sequencer;

    localparam int DQ_W  = 16;
    localparam int DM_W  = 2;
    localparam int DQS_W = 2;
    localparam int CWL   = 5;
    localparam int CL    = 6;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [DQ_W*8-1:0] last_rd;

    ddr3_dq_burst_sequencer_if #(.DQ_W(DQ_W), .DM_W(DM_W), .DQS_W(DQS_W)) bus ();

    ddr3_dq_burst_sequencer #(
        .DQ_W(DQ_W), .DM_W(DM_W), .DQS_W(DQS_W), .BL(8), .CWL(CWL), .CL(CL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.wr_start = 1'b0;
            bus.rd_start = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        logic [3:0] ctrl;
        logic [DM_W+2*DQS_W+DQ_W-1:0] pad;
        ctrl = {bus.ddr3_rw, bus.busy, bus.cmd_err, bus.rd_valid};
        pad  = {bus.ddr3_dm_tdqs_out, bus.ddr3_dqs_out, bus.ddr3_dqs_n_out, bus.ddr3_data_out};
        n_tests++;
        if (ctrl !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL %s_ctrl: got %b, expected 1000", tag, ctrl);
        end
        n_tests++;
        if (pad !== {{DM_W{1'b0}}, {DQS_W{1'b0}}, {DQS_W{1'b1}}, {DQ_W{1'b0}}}) begin
            n_fail++;
            $display("[TB] FAIL %s_pad: got %h, expected dqs_n all ones, rest 0", tag, pad);
        end
        n_tests++;
        if (bus.ddr3_data_all_out !== '0 || bus.rd_data !== '0) begin
            n_fail++;
            $display("[TB] FAIL %s_wide: got all_out=%h rd_data=%h, expected 0/0",
                     tag, bus.ddr3_data_all_out, bus.rd_data);
        end
    endtask

    // Caller sits just after a negedge; the start is sampled at the next posedge.
    task automatic do_write(input logic ramp, input logic with_rd, input int poke_k,
                            input logic poke_wr);
        logic [DQ_W-1:0]   beats [8];
        logic [DM_W-1:0]   masks [8];
        logic [DQ_W*8-1:0] all;
        logic [3:0]        exp_ctrl, got_ctrl;
        logic [DM_W+2*DQS_W+DQ_W-1:0] exp_pad, got_pad;
        logic [DQ_W*8-1:0] exp_all;
        int b;
        for (int i = 0; i < 8; i++) begin
            beats[i] = ramp ? DQ_W'(i + 1) : DQ_W'($urandom);
            masks[i] = ramp ? '0 : DM_W'($urandom);
            all[i*DQ_W +: DQ_W]      = beats[i];
            bus.wr_data[i*DQ_W +: DQ_W] = beats[i];
            bus.wr_mask[i*DM_W +: DM_W] = masks[i];
        end
        bus.wr_start = 1'b1;
        bus.rd_start = with_rd;
        for (int k = 1; k <= CWL + 9; k++) begin
            @(negedge clk);
            b = k - CWL;
            exp_ctrl = {!(k >= CWL - 1 && k <= CWL + 7), (k <= CWL + 8),
                        ((k == 1) && with_rd) || (k == poke_k + 1), 1'b0};
            if (b >= 0 && b <= 7) begin
                exp_pad = {masks[b], (b % 2 == 0) ? {DQS_W{1'b1}} : {DQS_W{1'b0}},
                           (b % 2 == 0) ? {DQS_W{1'b0}} : {DQS_W{1'b1}}, beats[b]};
                exp_all = all;
            end else begin
                exp_pad = {{DM_W{1'b0}}, {DQS_W{1'b0}}, {DQS_W{1'b1}}, {DQ_W{1'b0}}};
                exp_all = '0;
            end
            got_ctrl = {bus.ddr3_rw, bus.busy, bus.cmd_err, bus.rd_valid};
            got_pad  = {bus.ddr3_dm_tdqs_out, bus.ddr3_dqs_out, bus.ddr3_dqs_n_out,
                        bus.ddr3_data_out};
            n_tests++;
            if (got_ctrl !== exp_ctrl) begin
                n_fail++;
                $display("[TB] FAIL wr_ctrl k=%0d: got rw/busy/err/valid=%b, expected %b",
                         k, got_ctrl, exp_ctrl);
            end
            n_tests++;
            if (got_pad !== exp_pad) begin
                n_fail++;
                $display("[TB] FAIL wr_pad k=%0d: got dm/dqs/dqs_n/dq=%h, expected %h",
                         k, got_pad, exp_pad);
            end
            n_tests++;
            if (bus.ddr3_data_all_out !== exp_all || bus.rd_data !== last_rd) begin
                n_fail++;
                $display("[TB] FAIL wr_wide k=%0d: got all_out=%h rd_data=%h, expected %h/%h",
                         k, bus.ddr3_data_all_out, bus.rd_data, exp_all, last_rd);
            end
            bus.wr_start = 1'b0;
            bus.rd_start = 1'b0;
            if (k == 1) begin
                bus.wr_data = {4{$urandom}};
                bus.wr_mask = DM_W*8'($urandom);
            end
            if (k == poke_k) begin
                if (poke_wr) bus.wr_start = 1'b1;
                else         bus.rd_start = 1'b1;
            end
        end
    endtask

    task automatic do_read(input int reset_k);
        logic [DQ_W-1:0]   beats [8];
        logic [DQ_W*8-1:0] assembled;
        logic [3:0]        exp_ctrl, got_ctrl;
        int b;
        for (int i = 0; i < 8; i++) begin
            beats[i] = DQ_W'($urandom);
            assembled[i*DQ_W +: DQ_W] = beats[i];
        end
        bus.rd_start = 1'b1;
        for (int k = 1; k <= CL + 9; k++) begin
            @(negedge clk);
            if (k == CL + 8) last_rd = assembled;
            exp_ctrl = {1'b1, (k <= CL + 8), 1'b0, (k == CL + 8)};
            got_ctrl = {bus.ddr3_rw, bus.busy, bus.cmd_err, bus.rd_valid};
            n_tests++;
            if (got_ctrl !== exp_ctrl) begin
                n_fail++;
                $display("[TB] FAIL rd_ctrl k=%0d: got rw/busy/err/valid=%b, expected %b",
                         k, got_ctrl, exp_ctrl);
            end
            n_tests++;
            if (bus.rd_data !== last_rd) begin
                n_fail++;
                $display("[TB] FAIL rd_data k=%0d: got %h, expected %h", k, bus.rd_data, last_rd);
            end
            bus.rd_start = 1'b0;
            b = k - CL;
            bus.ddr3_data_in = (b >= 0 && b <= 7) ? beats[b] : DQ_W'($urandom);
            if (k == reset_k) begin
                rst_n = 1'b0;
                last_rd = '0;
                #1;
                check_reset_values("rst_mid_read");
                @(negedge clk);
                rst_n = 1'b1;
                for (int j = 0; j < CL + 10; j++) begin
                    @(negedge clk);
                    n_tests++;
                    if ({bus.ddr3_rw, bus.busy, bus.rd_valid} !== 3'b100) begin
                        n_fail++;
                        $display("[TB] FAIL post_reset j=%0d: got rw/busy/valid=%b, expected 100",
                                 j, {bus.ddr3_rw, bus.busy, bus.rd_valid});
                    end
                end
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.wr_start = 1'b0;
        bus.rd_start = 1'b0;
        bus.wr_data = '0;
        bus.wr_mask = '0;
        bus.ddr3_data_in = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        idle(2);
        check_reset_values("after_reset");
    endtask

    task automatic test_write();
        idle(2);
        do_write(1'b1, 1'b0, -1, 1'b0);
        for (int r = 0; r < 3; r++) begin
            idle(1 + r);
            do_write(1'b0, 1'b0, -1, 1'b0);
        end
    endtask

    task automatic test_read();
        for (int r = 0; r < 3; r++) begin
            idle(2);
            do_read(-1);
        end
    endtask

    task automatic test_collision();
        idle(2);
        do_write(1'b0, 1'b1, -1, 1'b0);
    endtask

    task automatic test_start_while_busy();
        idle(2);
        do_write(1'b0, 1'b0, CWL + 3, 1'b0);
        idle(2);
        do_write(1'b0, 1'b0, 2, 1'b1);
        idle(2);
        do_write(1'b0, 1'b0, CWL + 8, 1'b0);
    endtask

    task automatic test_reset_mid_read();
        idle(2);
        do_read(CL + 4);
    endtask

    task automatic test_back_to_back();
        idle(2);
        do_read(-1);
        idle(1);
        do_write(1'b0, 1'b0, -1, 1'b0);
        do_read(-1);
        do_write(1'b0, 1'b0, -1, 1'b0);
    endtask

    initial begin
        clk     = 1'b0;
        n_tests = 0;
        n_fail  = 0;
        last_rd = '0;
        test_reset();
        test_write();
        test_read();
        test_collision();
        test_start_while_busy();
        test_reset_mid_read();
        test_back_to_back();
        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
